// File: rtl/pixel_batch_sequencer.sv
// Batch coordinate generator: walks the visible frame NUM_PIXELS pixels at a time,
// one batch per accepted request, restarting on each new_frame pulse.
module pixel_batch_sequencer #(
    parameter int NUM_PIXELS  = 8,
    parameter int H_VISIBLE   = 640,
    parameter int V_VISIBLE   = 480,
    parameter int COORD_WIDTH = 10,
    parameter int FRAME_WIDTH = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              new_frame,
    input  logic                              batch_req,
    output logic                              batch_valid,
    output logic [COORD_WIDTH-1:0]            batch_x,
    output logic [COORD_WIDTH-1:0]            batch_y,
    output logic [NUM_PIXELS*COORD_WIDTH-1:0] lane_x,
    output logic                              batch_last,
    output logic [FRAME_WIDTH-1:0]            frame_count,
    output logic                              frame_done,
    output logic                              frame_overrun
);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    // One extra bit so the x + NUM_PIXELS compare against H_VISIBLE cannot wrap.
    localparam logic [COORD_WIDTH:0]   H_END  = (COORD_WIDTH+1)'(H_VISIBLE);
    localparam logic [COORD_WIDTH:0]   X_STEP = (COORD_WIDTH+1)'(NUM_PIXELS);
    localparam logic [COORD_WIDTH-1:0] LAST_X = COORD_WIDTH'(H_VISIBLE - NUM_PIXELS);
    localparam logic [COORD_WIDTH-1:0] LAST_Y = COORD_WIDTH'(V_VISIBLE - 1);

    state_t                            state_reg, state_next;
    logic [COORD_WIDTH-1:0]            x_reg, x_next;
    logic [COORD_WIDTH-1:0]            y_reg, y_next;
    logic [NUM_PIXELS*COORD_WIDTH-1:0] lane_reg, lane_next, lane_init;
    logic                              last_reg, last_next;
    logic                              overrun_reg, overrun_next;
    logic [FRAME_WIDTH-1:0]            frame_reg, frame_next;
    logic [COORD_WIDTH:0]              x_wide;

    always_comb begin
        state_next   = state_reg;
        x_next       = x_reg;
        y_next       = y_reg;
        frame_next   = frame_reg;
        overrun_next = 1'b0;
        x_wide       = {1'b0, x_reg} + X_STEP;

        // new_frame wins over a same-cycle request; that request is dropped.
        if (new_frame) begin
            x_next       = '0;
            y_next       = '0;
            frame_next   = frame_reg + FRAME_WIDTH'(1);
            overrun_next = (state_reg == ISSUE);
            state_next   = ISSUE;
        end else if (state_reg == ISSUE && batch_req) begin
            if (last_reg) begin
                state_next = DONE;
            end else if (x_wide == H_END) begin
                x_next = '0;
                y_next = y_reg + COORD_WIDTH'(1);
            end else begin
                x_next = x_wide[COORD_WIDTH-1:0];
            end
        end

        last_next = (x_next == LAST_X) && (y_next == LAST_Y);
    end

    // Lane coordinates are precomputed from the next x so they register alongside it.
    generate
        for (genvar gi = 0; gi < NUM_PIXELS; gi++) begin : g_lane
            assign lane_next[gi*COORD_WIDTH +: COORD_WIDTH] = x_next + COORD_WIDTH'(gi);
            assign lane_init[gi*COORD_WIDTH +: COORD_WIDTH] = COORD_WIDTH'(gi);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            x_reg       <= '0;
            y_reg       <= '0;
            lane_reg    <= lane_init;
            last_reg    <= 1'b0;
            frame_reg   <= '1;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            x_reg       <= x_next;
            y_reg       <= y_next;
            lane_reg    <= lane_next;
            last_reg    <= last_next;
            frame_reg   <= frame_next;
            overrun_reg <= overrun_next;
        end
    end

    assign batch_valid   = (state_reg == ISSUE);
    assign frame_done    = (state_reg == DONE);
    assign batch_x       = x_reg;
    assign batch_y       = y_reg;
    assign lane_x        = lane_reg;
    assign batch_last    = last_reg;
    assign frame_count   = frame_reg;
    assign frame_overrun = overrun_reg;

endmodule
